// File: rtl/reward_calc_unit.sv
// reward_calc_unit: scans the neighbor table for the requested action node and computes a saturated reward.
// Define REWARD_BATTERY_EN to include the battery term (adds the RD_BAT/CAP_BAT fetch).
module reward_calc_unit #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int MAX_NEIGHBORS = 64,
  parameter int ADDR_STRIDE   = 2,
  parameter int NID_BASE      = 'h48,
  parameter int CID_BASE      = 'hC8,
  parameter int BAT_BASE      = 'h148,
  parameter int CLUSTER_BONUS = 10,
  parameter int HOP_PENALTY   = 6,
  parameter int BATT_SHIFT    = 4,
  localparam int CNT_W        = $clog2(MAX_NEIGHBORS + 1)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  start_i,
  input  logic [WORD_WIDTH-1:0] my_node_id_i,
  input  logic [WORD_WIDTH-1:0] my_cluster_id_i,
  input  logic [WORD_WIDTH-1:0] action_i,
  input  logic [WORD_WIDTH-1:0] besthop_i,
  input  logic [CNT_W-1:0]      num_neighbors_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [WORD_WIDTH-1:0] mem_rd_data_i,
  output logic [WORD_WIDTH-1:0] reward_out_o,
  output logic                  miss_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int SUM_W = WORD_WIDTH + 2;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(WORD_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(WORD_WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_NID  = 4'd1,
    CMP_NID = 4'd2,
    RD_CID  = 4'd3,
    CAP_CID = 4'd4,
`ifdef REWARD_BATTERY_EN
    RD_BAT  = 4'd5,
    CAP_BAT = 4'd6,
`endif
    CALC    = 4'd7,
    DONE    = 4'd8
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        idx_q;
  logic [CNT_W-1:0]        nn_q;
  logic [CNT_W-1:0]        nn_clamp_s;
  logic [WORD_WIDTH-1:0]   my_cid_q;
  logic [WORD_WIDTH-1:0]   action_q;
  logic [WORD_WIDTH-1:0]   besthop_q;
  logic [WORD_WIDTH-1:0]   node_id_unused_q;
  logic [WORD_WIDTH-1:0]   cid_q;
  logic                    empty_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [WORD_WIDTH-1:0]   reward_q;
  logic [WORD_WIDTH-1:0]   reward_d;
  logic                    miss_q;
  logic                    busy_q;
  logic                    done_q;
  logic signed [SUM_W-1:0] bat_term_s;
  logic signed [SUM_W-1:0] sum_s;

`ifdef REWARD_BATTERY_EN
  logic [WORD_WIDTH-1:0]   bat_q;
  assign bat_term_s = SUM_W'(bat_q >> BATT_SHIFT);
`else
  localparam int batt_cfg_unused = BAT_BASE + BATT_SHIFT;
  assign bat_term_s = {SUM_W{1'b0}};
`endif

  function automatic logic [ADDR_WIDTH-1:0] tbl_addr(input int base, input logic [CNT_W-1:0] idx);
    return ADDR_WIDTH'(base) + ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STRIDE);
  endfunction

  assign nn_clamp_s = (num_neighbors_i > CNT_W'(MAX_NEIGHBORS)) ? CNT_W'(MAX_NEIGHBORS) : num_neighbors_i;

  // Reward sum in a widened signed domain, clamped to the signed output range.
  always_comb begin
    sum_s = ((cid_q == my_cid_q) ? SUM_W'(CLUSTER_BONUS) : {SUM_W{1'b0}})
          + bat_term_s
          - ((action_q != besthop_q) ? SUM_W'(HOP_PENALTY) : {SUM_W{1'b0}});
    if (sum_s > SAT_MAX) begin
      reward_d = SAT_MAX[WORD_WIDTH-1:0];
    end else if (sum_s < SAT_MIN) begin
      reward_d = SAT_MIN[WORD_WIDTH-1:0];
    end else begin
      reward_d = sum_s[WORD_WIDTH-1:0];
    end
  end

  // Control FSM; every output is registered and en_i gates all updates.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      nn_q             <= '0;
      my_cid_q         <= '0;
      action_q         <= '0;
      besthop_q        <= '0;
      node_id_unused_q <= '0;
      cid_q            <= '0;
      empty_q          <= 1'b0;
      mem_addr_q       <= '0;
      reward_q         <= '0;
      miss_q           <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
`ifdef REWARD_BATTERY_EN
      bat_q            <= '0;
`endif
    end else if (en_i) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            my_cid_q         <= my_cluster_id_i;
            action_q         <= action_i;
            besthop_q        <= besthop_i;
            node_id_unused_q <= my_node_id_i;
            nn_q             <= nn_clamp_s;
            idx_q            <= '0;
            busy_q           <= 1'b1;
            // An empty table detours through CALC so its done lands one edge later.
            if (nn_clamp_s == {CNT_W{1'b0}}) begin
              empty_q <= 1'b1;
              state_q <= CALC;
            end else begin
              empty_q    <= 1'b0;
              mem_addr_q <= tbl_addr(NID_BASE, {CNT_W{1'b0}});
              state_q    <= RD_NID;
            end
          end
        end
        RD_NID: state_q <= CMP_NID;
        CMP_NID: begin
          if (mem_rd_data_i == action_q) begin
            mem_addr_q <= tbl_addr(CID_BASE, idx_q);
            state_q    <= RD_CID;
          end else if (idx_q == nn_q - CNT_W'(1)) begin
            reward_q <= '0;
            miss_q   <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            idx_q      <= idx_q + CNT_W'(1);
            mem_addr_q <= tbl_addr(NID_BASE, idx_q + CNT_W'(1));
            state_q    <= RD_NID;
          end
        end
        RD_CID: state_q <= CAP_CID;
        CAP_CID: begin
          cid_q <= mem_rd_data_i;
`ifdef REWARD_BATTERY_EN
          mem_addr_q <= tbl_addr(BAT_BASE, idx_q);
          state_q    <= RD_BAT;
`else
          state_q    <= CALC;
`endif
        end
`ifdef REWARD_BATTERY_EN
        RD_BAT: state_q <= CAP_BAT;
        CAP_BAT: begin
          bat_q   <= mem_rd_data_i;
          state_q <= CALC;
        end
`endif
        CALC: begin
          reward_q <= empty_q ? {WORD_WIDTH{1'b0}} : reward_d;
          miss_q   <= empty_q;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr_o   = mem_addr_q;
  assign reward_out_o = reward_q;
  assign miss_o       = miss_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
